// File: rtl/acondicionador_botones_pkg.sv
// Shared types, default timing and the counter-width helper for the pushbutton conditioner.
package botones_pkg;

  typedef logic [1:0] estado_t;

  localparam estado_t REPOSO = 2'd0;
  localparam estado_t ESPERA = 2'd1;
  localparam estado_t REPITE = 2'd2;

  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int REPEAT_DELAY_DEF    = 25000000;
  localparam int REPEAT_PERIOD_DEF   = 10000000;

  // Bits needed to hold 0..max_val, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/acondicionador_botones_if.sv
// Pin-side buttons and sequencer-side command pulses of the pushbutton conditioner.
interface acondicionador_botones_if;
  logic       btn_avanzar;
  logic       btn_reiniciar;
  logic       avanzar;
  logic       reiniciar;
  logic [1:0] presionado;

  modport master (
    output btn_avanzar,
    output btn_reiniciar,
    input  avanzar,
    input  reiniciar,
    input  presionado
  );

  modport slave (
    input  btn_avanzar,
    input  btn_reiniciar,
    output avanzar,
    output reiniciar,
    output presionado
  );
endinterface

// File: rtl/acondicionador_botones_antirrebote.sv
// One button: two-flop synchroniser, counter debounce and a registered press-edge pulse.
module antirrebote
  import botones_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic nivel,
  output logic flanco
);

  localparam int   CW          = cnt_width(DEBOUNCE_CYCLES);
  localparam logic NIVEL_SUELTO = ACTIVE_LOW ? 1'b1 : 1'b0;

  logic          sync1;
  logic          sync2;
  logic          muestra;
  logic [CW-1:0] cnt;

  // Polarity is normalised after the second flop so everything downstream sees pressed = 1.
  assign muestra = ACTIVE_LOW ? ~sync2 : sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= NIVEL_SUELTO;
      sync2  <= NIVEL_SUELTO;
      nivel  <= 1'b0;
      cnt    <= '0;
      flanco <= 1'b0;
    end else begin
      sync1  <= btn;
      sync2  <= sync1;
      flanco <= 1'b0;
      if (muestra == nivel) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
        nivel  <= muestra;
        cnt    <= '0;
        flanco <= muestra;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/acondicionador_botones.sv
// Turns the raw advance/restart buttons into single-cycle command pulses, with auto-repeat on advance.
//
// state  | meaning
// REPOSO | idle or held with repeat disabled; a press edge issues one avanzar pulse
// ESPERA | held after the first pulse, counting REPEAT_DELAY before repeating
// REPITE | held, issuing a pulse every REPEAT_PERIOD cycles
module acondicionador_botones
  import botones_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
  parameter bit REPEAT_EN       = 1'b1,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  acondicionador_botones_if.slave  bus
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = cnt_width(RMAX);

  logic          nivel_a;
  logic          flanco_a;
  logic          nivel_r;
  logic          flanco_r;
  estado_t       estado;
  estado_t       estado_sig;
  logic [RW-1:0] rep_cnt;
  logic [RW-1:0] rep_sig;
  logic          pulso_a;
  logic          avanzar_q;
  logic          reiniciar_q;

  antirrebote #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .ACTIVE_LOW      (ACTIVE_LOW)
  ) u_antirrebote_avanzar (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn    (bus.btn_avanzar),
    .nivel  (nivel_a),
    .flanco (flanco_a)
  );

  antirrebote #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .ACTIVE_LOW      (ACTIVE_LOW)
  ) u_antirrebote_reiniciar (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn    (bus.btn_reiniciar),
    .nivel  (nivel_r),
    .flanco (flanco_r)
  );

  // Release has precedence over a due repeat pulse in the same cycle.
  always_comb begin
    estado_sig = estado;
    rep_sig    = rep_cnt;
    pulso_a    = 1'b0;
    case (estado)
      REPOSO: begin
        if (flanco_a) begin
          pulso_a = 1'b1;
          rep_sig = '0;
          if (REPEAT_EN) estado_sig = ESPERA;
        end
      end
      ESPERA: begin
        if (!nivel_a) begin
          estado_sig = REPOSO;
          rep_sig    = '0;
        end else if (rep_cnt == RW'(REPEAT_DELAY - 1)) begin
          pulso_a    = 1'b1;
          rep_sig    = '0;
          estado_sig = REPITE;
        end else begin
          rep_sig = rep_cnt + RW'(1);
        end
      end
      REPITE: begin
        if (!nivel_a) begin
          estado_sig = REPOSO;
          rep_sig    = '0;
        end else if (rep_cnt == RW'(REPEAT_PERIOD - 1)) begin
          pulso_a = 1'b1;
          rep_sig = '0;
        end else begin
          rep_sig = rep_cnt + RW'(1);
        end
      end
      default: begin
        estado_sig = REPOSO;
        rep_sig    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado      <= REPOSO;
      rep_cnt     <= '0;
      avanzar_q   <= 1'b0;
      reiniciar_q <= 1'b0;
    end else begin
      estado      <= estado_sig;
      rep_cnt     <= rep_sig;
      // A coincident restart wins; the dropped advance does not disturb repeat timing.
      avanzar_q   <= pulso_a & ~flanco_r;
      reiniciar_q <= flanco_r;
    end
  end

  assign bus.avanzar    = avanzar_q;
  assign bus.reiniciar  = reiniciar_q;
  assign bus.presionado = {nivel_r, nivel_a};

endmodule

// File: tb/tb_acondicionador_botones.sv
// Directed-vector bench for acondicionador_botones with short debounce and repeat timing.
module tb_acondicionador_botones;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  acondicionador_botones_if bus ();

  acondicionador_botones #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3),
    .REPEAT_EN       (1'b1),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic paso();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    rst_n = 1'b0;
    bus.btn_avanzar   = 1'b1;
    bus.btn_reiniciar = 1'b1;
    #1;
    obs = {bus.reiniciar, bus.avanzar, bus.presionado};
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("FAIL reset_async got=%b want=0000", obs);
    end
    for (int i = 0; i < 5; i++) begin
      paso();
      obs = {bus.reiniciar, bus.avanzar, bus.presionado};
      checks++;
      if (obs !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold cycle=%0d got=%b want=0000", i, obs);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      paso();
      obs = {bus.reiniciar, bus.avanzar, bus.presionado};
      checks++;
      if (obs !== 4'b0000) begin
        errors++;
        $display("FAIL reset_idle cycle=%0d got=%b want=0000", i, obs);
      end
    end
  endtask

  task automatic test_press_short();
    logic [3:0] obs, exp;
    for (int e = 0; e <= 30; e++) begin
      bus.btn_avanzar = (e < 9) ? 1'b0 : 1'b1;
      paso();
      obs = {bus.reiniciar, bus.avanzar, bus.presionado};
      exp = {1'b0, (e == 7), 1'b0, (e >= 6 && e <= 14)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL short_press edge=%0d got=%b want=%b", e, obs, exp);
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] obs, exp;
    for (int e = 0; e <= 60; e++) begin
      if (e < 20) bus.btn_reiniciar = ((e / 2) % 2 == 1) ? 1'b1 : 1'b0;
      else        bus.btn_reiniciar = (e < 41) ? 1'b0 : 1'b1;
      paso();
      obs = {bus.reiniciar, bus.avanzar, bus.presionado};
      exp = {(e == 27), 1'b0, (e >= 26 && e <= 46), 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL bounce edge=%0d got=%b want=%b", e, obs, exp);
      end
    end
  endtask

  task automatic test_autorepeat();
    logic [3:0] obs, exp;
    logic       av;
    for (int e = 0; e <= 60; e++) begin
      bus.btn_avanzar = (e < 40) ? 1'b0 : 1'b1;
      paso();
      av  = (e == 7) || (e >= 17 && e <= 44 && ((e - 17) % 3) == 0);
      obs = {bus.reiniciar, bus.avanzar, bus.presionado};
      exp = {1'b0, av, 1'b0, (e >= 6 && e <= 45)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL autorepeat edge=%0d got=%b want=%b", e, obs, exp);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] obs, exp;
    logic       av, pr;
    for (int e = 0; e <= 45; e++) begin
      bus.btn_avanzar   = (e < 26) ? 1'b0 : 1'b1;
      bus.btn_reiniciar = (e < 26) ? 1'b0 : 1'b1;
      paso();
      av  = (e >= 17 && e <= 32 && ((e - 17) % 3) == 0);
      pr  = (e >= 6 && e <= 31);
      obs = {bus.reiniciar, bus.avanzar, bus.presionado};
      exp = {(e == 7), av, pr, pr};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL simultaneous edge=%0d got=%b want=%b", e, obs, exp);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] obs, exp;
    logic       av;
    for (int e = 0; e <= 23; e++) begin
      bus.btn_avanzar = 1'b0;
      paso();
      av  = (e == 7) || (e == 17) || (e == 20) || (e == 23);
      obs = {bus.reiniciar, bus.avanzar, bus.presionado};
      exp = {1'b0, av, 1'b0, (e >= 6)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL mid_reset_pre edge=%0d got=%b want=%b", e, obs, exp);
      end
    end
    rst_n = 1'b0;
    #1;
    obs = {bus.reiniciar, bus.avanzar, bus.presionado};
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset_async got=%b want=0000", obs);
    end
    for (int i = 0; i < 3; i++) begin
      paso();
      obs = {bus.reiniciar, bus.avanzar, bus.presionado};
      checks++;
      if (obs !== 4'b0000) begin
        errors++;
        $display("FAIL mid_reset_hold cycle=%0d got=%b want=0000", i, obs);
      end
    end
    rst_n = 1'b1;
    for (int e = 0; e <= 40; e++) begin
      bus.btn_avanzar = (e < 25) ? 1'b0 : 1'b1;
      paso();
      av  = (e == 7) || (e >= 17 && e <= 29 && ((e - 17) % 3) == 0);
      obs = {bus.reiniciar, bus.avanzar, bus.presionado};
      exp = {1'b0, av, 1'b0, (e >= 6 && e <= 30)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL mid_reset_post edge=%0d got=%b want=%b", e, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_press_short();
    test_bounce();
    test_autorepeat();
    test_simultaneous();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/acondicionador_botones.md
Name: acondicionador_botones

Overview:
Conditions two raw board pushbuttons into the single-cycle `avanzar` and `reiniciar` command pulses consumed by the LED sequencer. Per button, it provides:
- synchronisation;
- counter-based debounce;
- press-edge detection.

`avanzar` also auto-repeats while held. The block sits between the board pins and the LED controller.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable samples needed to accept a new button level (10 ms at 50 MHz); must be >= 1
- REPEAT_DELAY, 25000000, cycles of holding after the first `avanzar` pulse before auto-repeat starts; must be >= 1
- REPEAT_PERIOD, 10000000, cycles between auto-repeat pulses; must be >= 1
- REPEAT_EN, 1, 1 = auto-repeat enabled on `avanzar`, 0 = one pulse per press
- ACTIVE_LOW, 1, 1 = a raw button reads 0 when pressed

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- btn_avanzar  input  1  raw, asynchronous advance button
- btn_reiniciar  input  1  raw, asynchronous restart button
- avanzar  output  1  one-cycle advance pulse, registered
- reiniciar  output  1  one-cycle restart pulse, registered
- presionado  output  2  debounced pressed levels; [0] = avanzar, [1] = reiniciar; 1 = pressed

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values:
  - `avanzar`, `reiniciar`, `presionado` = 0.
  - Synchroniser flops take the released raw level (1 when ACTIVE_LOW = 1).
  - Debounce counters = 0; repeat FSM = REPOSO.
- Synchroniser: two flops per button. The polarity is normalised after the second flop, so internally pressed = 1.
- Debounce, per button:
  - The stable register `estable` holds the accepted level.
  - Counter clears whenever the synchronised sample equals `estable`, and increments whenever it differs.
  - When the counter reaches DEBOUNCE_CYCLES, `estable` takes the sample and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles changes nothing.
- Latency: a raw press held steady produces its pulse exactly DEBOUNCE_CYCLES + 3 rising edges after the first edge that samples it pressed. The pulse is 1 cycle wide. `presionado` rises one cycle before the pulse.
- Release produces no pulse.
- `reiniciar`: exactly one pulse per accepted press. It never repeats.
- `avanzar` repeat FSM, with states REPOSO / ESPERA / REPITE and counter `rep_cnt`:
  - REPOSO: on an accepted press, issue a pulse. Go to ESPERA if REPEAT_EN = 1, else to REPITE-disabled hold (stay REPOSO-held, no further pulses until release).
  - ESPERA: `rep_cnt` increments each cycle. When REPEAT_DELAY cycles have elapsed since the first pulse, issue a pulse, clear `rep_cnt`, go to REPITE.
  - REPITE: issue a pulse every REPEAT_PERIOD cycles.
  - In any state, an accepted release goes to REPOSO, clears `rep_cnt`, and issues no pulse.
- Simultaneous events: if both outputs would pulse in the same cycle, only `reiniciar` is asserted. That `avanzar` pulse is dropped and the repeat timing is unaffected.
- Reset mid-operation: all state returns to reset values immediately; a pulse in flight is cut. A button held through reset release is seen as a new press, giving one pulse after DEBOUNCE_CYCLES + 3 edges.
- Widths: each counter is $clog2(max value + 1) bits. There are no wrap-around paths, because every counter clears at its terminal count.

Decomposition:
- Package `botones_pkg`:
  - FSM state typedef: REPOSO, ESPERA, REPITE.
  - Default timing constants.
  - Helper function for counter width.
- Sub-module `antirrebote`:
  - Instantiated once per button.
  - Contains the synchroniser, the debounce counter and `estable`.
  - Outputs the level and a one-cycle press-edge signal.
- The top level contains the repeat FSM, the priority rule and the output registers.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES = 4, REPEAT_DELAY = 10, REPEAT_PERIOD = 3, ACTIVE_LOW = 1.
- Reset hold: both buttons at 1 and `rst_n` low for 5 cycles, then run 50 cycles -> all outputs 0 throughout; no pulses.
- Clean short press: `btn_avanzar` = 0 for 9 cycles, then 1 -> exactly one `avanzar` pulse, 7 edges after the first pressed sample. `presionado[0]` is high from edge 6. No pulse on release.
- Bounce: `btn_reiniciar` toggles every 2 cycles for 20 cycles, then holds 0 -> exactly one `reiniciar` pulse, 7 edges after the final stable 0. No pulses during the bouncing.
- Auto-repeat: `btn_avanzar` held 0 for 40 cycles -> first pulse at t0, then pulses at t0+10, t0+13, t0+16, ... until release. After release, no pulse.
- Simultaneous press: both buttons go to 0 on the same edge -> at t0, `reiniciar` = 1 and `avanzar` = 0. The next `avanzar` pulse still occurs at t0+10.
- Mid-operation reset: `rst_n` is pulled low during REPITE while `btn_avanzar` stays held.
  - While `rst_n` is low: outputs are 0 asynchronously, with no clock needed.
  - After `rst_n` is released: one `avanzar` pulse 7 edges later, then repeats at +10 and +13.
